// File: rtl/jtframe_sdram_slot_rq_pkg.sv
// Shared constants for the SDRAM request slot and its cache entries.
package jtframe_sdram_slot_rq_pkg;

    // Width of one SDRAM data word
    localparam int SDRAM_DW = 16;

    // Client data widths the slot supports
    localparam int DW_BYTE = 8;
    localparam int DW_WORD = 16;

    // True when a client data width can be served by the slot
    function automatic bit dw_is_legal(input int dw);
        return (dw == DW_BYTE) || (dw == DW_WORD);
    endfunction

endpackage

// File: rtl/jtframe_slot_cache_entry.sv
// One read-cache line: valid flag, SDRAM word-address tag and 16-bit data.
module jtframe_slot_cache_entry
    import jtframe_sdram_slot_rq_pkg::*;
#(
    parameter int SDRAMW = 22
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,        // drop the line (wins over fill)
    input  logic                fill,       // load tag/data and mark valid
    input  logic                inval,      // drop the line if its tag matches
    input  logic [SDRAMW-1:0]   fill_tag,
    input  logic [SDRAM_DW-1:0] fill_data,
    input  logic [SDRAMW-1:0]   cmp_addr,
    output logic                match,
    output logic [SDRAM_DW-1:0] data
);

    logic                valid_q;
    logic [SDRAMW-1:0]   tag_q;
    logic [SDRAM_DW-1:0] data_q;

    // Valid flag: clear and invalidate take priority over a fill
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else if (clr || (inval && match)) begin
            valid_q <= 1'b0;
        end else if (fill) begin
            valid_q <= 1'b1;
        end
    end

    // Payload load on fill
    // NOTE: tag and data are not reset; they are only observed through match, which is gated by valid_q.
    always_ff @(posedge clk) begin
        if (fill && !clr) begin
            tag_q  <= fill_tag;
            data_q <= fill_data;
        end
    end

    assign match = valid_q && (tag_q == cmp_addr);
    assign data  = data_q;

endmodule

// File: rtl/jtframe_sdram_slot_rq.sv
// Per-client SDRAM request slot: address translation, small read cache,
// miss/write requests towards the arbiter and client data_ok generation.
module jtframe_sdram_slot_rq
    import jtframe_sdram_slot_rq_pkg::*;
#(
    parameter int SDRAMW   = 22,
    parameter int AW       = 8,
    parameter int DW       = 16,
    parameter int WRITABLE = 0,
    parameter int LATCH    = 0,
    parameter int DOUBLE   = 0,
    parameter int OKLATCH  = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic [SDRAMW-1:0]   offset,
    input  logic [AW-1:0]       addr,
    input  logic                addr_ok,
    input  logic                wrin,
    input  logic [DW-1:0]       wrdata,
    output logic                req_rnw,
    output logic [SDRAMW-1:0]   sdram_addr,
    input  logic [SDRAM_DW-1:0] din,
    input  logic                din_ok,
    input  logic                dst,
    input  logic                we,
    output logic [DW-1:0]       dout,
    output logic                req,
    output logic                data_ok
);

    localparam int NENT = (DOUBLE != 0) ? 2 : 1;

    logic [SDRAMW-1:0]   waddr;
    logic                is_write;
    logic                fill_ev;
    logic                wr_ev;
    logic                hit;
    logic [NENT-1:0]     match;
    logic [SDRAM_DW-1:0] ent_data [NENT];
    logic [SDRAM_DW-1:0] hitdata;
    logic [DW-1:0]       dout_sel;
    logic                wdone_q, wdone_d;
    logic                ptr_q, ptr_d;
    logic [SDRAMW-1:0]   last_addr_q;
    logic                ok_d;
    logic                unused_sig;

    // wrdata is driven onto the bus by the arbiter; dst carries no information here
    assign unused_sig = ^{dst, wrdata};

    // Byte clients address two bytes per SDRAM word
    assign waddr      = (DW == DW_BYTE) ? SDRAMW'(addr >> 1) : SDRAMW'(addr);
    assign sdram_addr = offset + waddr;

    assign is_write = (WRITABLE != 0) && wrin;
    assign req_rnw  = (WRITABLE != 0) ? ~wrin : 1'b1;
    assign fill_ev  = we && din_ok && !is_write;
    assign wr_ev    = we && din_ok && is_write;

    for (genvar i = 0; i < NENT; i++) begin : g_entry
        jtframe_slot_cache_entry #(.SDRAMW(SDRAMW)) u_entry (
            .clk       (clk),
            .rst_n     (rst_n),
            .clr       (clr),
            .fill      (fill_ev && (ptr_q == 1'(i))),
            .inval     (wr_ev),
            .fill_tag  (sdram_addr),
            .fill_data (din),
            .cmp_addr  (sdram_addr),
            .match     (match[i]),
            .data      (ent_data[i])
        );
    end

    assign hit = addr_ok && !is_write && (|match);
    assign req = is_write ? (addr_ok && !wdone_q) : (addr_ok && !hit);

    // Select the data of the matching cache line
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        hitdata = '0;
        for (int i = 0; i < NENT; i++) begin
            if (match[i]) hitdata = ent_data[i];
        end
    end

    if (DW == DW_BYTE) begin : g_byte
        assign dout_sel = addr[0] ? hitdata[15:8] : hitdata[7:0];
    end else begin : g_word
        assign dout_sel = DW'(hitdata);
    end

    // Next-state for write-done flag, replacement pointer and data_ok
    always_comb begin
        wdone_d = wdone_q;
        if (!addr_ok || (sdram_addr != last_addr_q)) begin
            wdone_d = 1'b0;
        end else if (wr_ev) begin
            wdone_d = 1'b1;
        end
        ptr_d = ptr_q;
        if ((DOUBLE != 0) && fill_ev && !clr) ptr_d = ~ptr_q;
        ok_d = addr_ok && (hit || wdone_q);
    end

    // Control state registers
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdone_q     <= 1'b0;
            ptr_q       <= 1'b0;
            last_addr_q <= '0;
        end else begin
            wdone_q     <= wdone_d;
            ptr_q       <= ptr_d;
            last_addr_q <= sdram_addr;
        end
    end

    if (LATCH != 0) begin : g_dout_reg
        logic [DW-1:0] dout_q;
        // Hold the last hit data for the client
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dout_q <= '0;
            end else if (hit) begin
                dout_q <= dout_sel;
            end
        end
        assign dout = dout_q;
    end else begin : g_dout_comb
        assign dout = dout_sel;
    end

    if (OKLATCH != 0) begin : g_ok_reg
        logic ok_q;
        // One-cycle registered data_ok
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ok_q <= 1'b0;
            end else begin
                ok_q <= ok_d;
            end
        end
        assign data_ok = ok_q;
    end else begin : g_ok_comb
        assign data_ok = ok_d;
    end

endmodule

// File: tb/tb_jtframe_sdram_slot_rq.sv
// Directed bench: a byte ROM slot, a latched word RAM slot and a two-entry ROM slot.
module tb_jtframe_sdram_slot_rq;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    // ROM slot, DW=8, single entry, combinational dout, registered data_ok
    logic        r_clr, r_addr_ok, r_wrin, r_din_ok, r_dst, r_we;
    logic [21:0] r_offset, r_sdram_addr;
    logic [7:0]  r_addr, r_wrdata, r_dout;
    logic [15:0] r_din;
    logic        r_req_rnw, r_req, r_data_ok;

    // RAM slot, DW=16, latched dout, registered data_ok
    logic        w_clr, w_addr_ok, w_wrin, w_din_ok, w_dst, w_we;
    logic [21:0] w_offset, w_sdram_addr;
    logic [7:0]  w_addr;
    logic [15:0] w_wrdata, w_dout, w_din;
    logic        w_req_rnw, w_req, w_data_ok;

    // ROM slot, DW=16, two entries, combinational dout and data_ok
    logic        d_clr, d_addr_ok, d_wrin, d_din_ok, d_dst, d_we;
    logic [21:0] d_offset, d_sdram_addr;
    logic [7:0]  d_addr;
    logic [15:0] d_wrdata, d_dout, d_din;
    logic        d_req_rnw, d_req, d_data_ok;

    jtframe_sdram_slot_rq #(.SDRAMW(22), .AW(8), .DW(8), .WRITABLE(0),
                            .LATCH(0), .DOUBLE(0), .OKLATCH(1)) u_rom8 (
        .clk(clk), .rst_n(rst_n), .clr(r_clr), .offset(r_offset), .addr(r_addr),
        .addr_ok(r_addr_ok), .wrin(r_wrin), .wrdata(r_wrdata), .req_rnw(r_req_rnw),
        .sdram_addr(r_sdram_addr), .din(r_din), .din_ok(r_din_ok), .dst(r_dst),
        .we(r_we), .dout(r_dout), .req(r_req), .data_ok(r_data_ok));

    jtframe_sdram_slot_rq #(.SDRAMW(22), .AW(8), .DW(16), .WRITABLE(1),
                            .LATCH(1), .DOUBLE(0), .OKLATCH(1)) u_ram16 (
        .clk(clk), .rst_n(rst_n), .clr(w_clr), .offset(w_offset), .addr(w_addr),
        .addr_ok(w_addr_ok), .wrin(w_wrin), .wrdata(w_wrdata), .req_rnw(w_req_rnw),
        .sdram_addr(w_sdram_addr), .din(w_din), .din_ok(w_din_ok), .dst(w_dst),
        .we(w_we), .dout(w_dout), .req(w_req), .data_ok(w_data_ok));

    jtframe_sdram_slot_rq #(.SDRAMW(22), .AW(8), .DW(16), .WRITABLE(0),
                            .LATCH(0), .DOUBLE(1), .OKLATCH(0)) u_dbl (
        .clk(clk), .rst_n(rst_n), .clr(d_clr), .offset(d_offset), .addr(d_addr),
        .addr_ok(d_addr_ok), .wrin(d_wrin), .wrdata(d_wrdata), .req_rnw(d_req_rnw),
        .sdram_addr(d_sdram_addr), .din(d_din), .din_ok(d_din_ok), .dst(d_dst),
        .we(d_we), .dout(d_dout), .req(d_req), .data_ok(d_data_ok));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic dbl_fill(input logic [7:0] a, input logic [15:0] d);
        d_addr = a;
        #1;
        check("dbl_fill_miss_req", 32'(d_req), 32'd1);
        d_we = 1'b1; d_din_ok = 1'b1; d_din = d;
        tick;
        d_we = 1'b0; d_din_ok = 1'b0; d_din = '0;
        #1;
        check("dbl_fill_hit_req", 32'(d_req), 32'd0);
    endtask

    initial begin
        {r_clr, r_addr_ok, r_wrin, r_din_ok, r_dst, r_we} = '0;
        r_offset = '0; r_addr = '0; r_wrdata = '0; r_din = '0;
        {w_clr, w_addr_ok, w_wrin, w_din_ok, w_dst, w_we} = '0;
        w_offset = '0; w_addr = '0; w_wrdata = '0; w_din = '0;
        {d_clr, d_addr_ok, d_wrin, d_din_ok, d_dst, d_we} = '0;
        d_offset = '0; d_addr = '0; d_wrdata = '0; d_din = '0;

        // Reset state
        #2 rst_n = 1'b0;
        #2;
        check("rst_rom_req",     32'(r_req),     32'd0);
        check("rst_rom_data_ok", 32'(r_data_ok), 32'd0);
        check("rst_rom_dout",    32'(r_dout),    32'd0);
        check("rst_ram_dout",    32'(w_dout),    32'd0);
        check("rst_ram_data_ok", 32'(w_data_ok), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        tick;

        // ROM byte slot: miss, fill, hit on upper byte
        r_offset = 22'h1000; r_addr = 8'h05; r_addr_ok = 1'b1;
        #1;
        check("rom_miss_req",   32'(r_req),        32'd1);
        check("rom_sdram_addr", 32'(r_sdram_addr), 32'h1002);
        check("rom_req_rnw",    32'(r_req_rnw),    32'd1);
        tick;
        check("rom_miss_ok",    32'(r_data_ok),    32'd0);
        r_we = 1'b1; r_din_ok = 1'b1; r_din = 16'hBEEF;
        tick;
        r_we = 1'b0; r_din_ok = 1'b0; r_din = '0;
        #1;
        check("rom_fill_req",   32'(r_req),     32'd0);
        check("rom_ok_latency", 32'(r_data_ok), 32'd0);
        check("rom_dout_hi",    32'(r_dout),    32'hBE);
        tick;
        check("rom_ok_hit",     32'(r_data_ok), 32'd1);

        // Same word, lower byte
        r_addr = 8'h04;
        #1;
        check("rom_lo_req",  32'(r_req),  32'd0);
        check("rom_lo_dout", 32'(r_dout), 32'hEF);
        tick;
        check("rom_lo_ok",   32'(r_data_ok), 32'd1);

        // clr invalidates
        r_clr = 1'b1;
        tick;
        r_clr = 1'b0;
        check("rom_clr_req", 32'(r_req), 32'd1);

        // clr in the same cycle as a fill: clr wins
        r_clr = 1'b1; r_we = 1'b1; r_din_ok = 1'b1; r_din = 16'h1111;
        tick;
        r_clr = 1'b0; r_we = 1'b0; r_din_ok = 1'b0; r_din = '0;
        check("rom_clr_fill_req", 32'(r_req), 32'd1);
        tick;
        check("rom_clr_fill_ok",  32'(r_data_ok), 32'd0);

        // din_ok without grant is ignored
        r_din_ok = 1'b1; r_din = 16'h2222;
        tick;
        r_din_ok = 1'b0; r_din = '0;
        check("rom_nogrant_req", 32'(r_req), 32'd1);

        // Refill
        r_we = 1'b1; r_din_ok = 1'b1; r_din = 16'hBEEF;
        tick;
        r_we = 1'b0; r_din_ok = 1'b0; r_din = '0;
        check("rom_refill_req", 32'(r_req), 32'd0);

        // addr_ok drops during a miss; late grant still fills
        r_addr = 8'h08;
        #1;
        check("rom_drop_req",   32'(r_req),        32'd1);
        check("rom_drop_saddr", 32'(r_sdram_addr), 32'h1004);
        r_addr_ok = 1'b0;
        #1;
        check("rom_drop_req_off", 32'(r_req), 32'd0);
        r_we = 1'b1; r_din_ok = 1'b1; r_din = 16'h1234;
        tick;
        r_we = 1'b0; r_din_ok = 1'b0; r_din = '0;
        r_addr_ok = 1'b1;
        #1;
        check("rom_late_fill_req",  32'(r_req),  32'd0);
        check("rom_late_fill_dout", 32'(r_dout), 32'h34);

        // RAM word slot: prefill 0x10, write it, then read misses
        w_offset = '0; w_addr = 8'h10; w_addr_ok = 1'b1; w_wrin = 1'b0;
        #1;
        check("ram_rd_req",     32'(w_req),     32'd1);
        check("ram_rd_req_rnw", 32'(w_req_rnw), 32'd1);
        w_we = 1'b1; w_din_ok = 1'b1; w_din = 16'hAAAA;
        tick;
        w_we = 1'b0; w_din_ok = 1'b0; w_din = '0;
        check("ram_fill_req",  32'(w_req),  32'd0);
        check("ram_latch_old", 32'(w_dout), 32'd0);
        tick;
        check("ram_latch_new", 32'(w_dout),    32'hAAAA);
        check("ram_rd_ok",     32'(w_data_ok), 32'd1);
        w_wrin = 1'b1; w_wrdata = 16'h5555;
        #1;
        check("ram_wr_req",     32'(w_req),     32'd1);
        check("ram_wr_req_rnw", 32'(w_req_rnw), 32'd0);
        tick;
        w_we = 1'b1; w_din_ok = 1'b1;
        tick;
        w_we = 1'b0; w_din_ok = 1'b0;
        check("ram_wdone_req",  32'(w_req),     32'd0);
        check("ram_wr_ok_lat",  32'(w_data_ok), 32'd0);
        tick;
        check("ram_wr_ok",      32'(w_data_ok), 32'd1);
        w_wrin = 1'b0;
        #1;
        check("ram_rd_after_wr_req", 32'(w_req),  32'd1);
        check("ram_latch_hold",      32'(w_dout), 32'hAAAA);
        w_addr_ok = 1'b0;
        tick;
        w_addr_ok = 1'b1; w_wrin = 1'b1;
        #1;
        check("ram_wdone_clr_req", 32'(w_req), 32'd1);
        w_addr_ok = 1'b0; w_wrin = 1'b0;

        // Two-entry slot: round-robin replacement
        d_offset = '0; d_addr_ok = 1'b1;
        dbl_fill(8'h20, 16'h2020);
        dbl_fill(8'h30, 16'h3030);
        d_addr = 8'h20;
        #1;
        check("dbl_hit20_req",  32'(d_req),     32'd0);
        check("dbl_hit20_dout", 32'(d_dout),    32'h2020);
        check("dbl_hit20_ok",   32'(d_data_ok), 32'd1);
        d_addr = 8'h30;
        #1;
        check("dbl_hit30_req",  32'(d_req),  32'd0);
        check("dbl_hit30_dout", 32'(d_dout), 32'h3030);
        tick;
        dbl_fill(8'h40, 16'h4040);
        d_addr = 8'h20;
        #1;
        check("dbl_evict20_req", 32'(d_req),     32'd1);
        check("dbl_evict20_ok",  32'(d_data_ok), 32'd0);
        d_addr = 8'h30;
        #1;
        check("dbl_keep30_req",  32'(d_req),  32'd0);
        check("dbl_keep30_dout", 32'(d_dout), 32'h3030);
        d_addr = 8'h40;
        #1;
        check("dbl_hit40_dout",  32'(d_dout), 32'h4040);

        // Asynchronous reset with a pending request
        tick;
        check("rom_pre_rst_ok", 32'(r_data_ok), 32'd1);
        r_addr = 8'h06;
        #1;
        check("rom_pend_req", 32'(r_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rom_async_rst_ok",   32'(r_data_ok), 32'd0);
        check("rom_async_rst_dout", 32'(r_dout),    32'd0);
        @(negedge clk) rst_n = 1'b1;
        #1;
        check("rom_post_rst_req",   32'(r_req),        32'd1);
        check("rom_post_rst_saddr", 32'(r_sdram_addr), 32'h1003);
        r_addr = 8'h08;
        #1;
        check("rom_post_rst_inval", 32'(r_req), 32'd1);
        r_addr = 8'h04;
        #1;
        check("rom_post_rst_inval2", 32'(r_req), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
